memtest_databus_engine: RTL and testbench
=========================================

Name: memtest_databus_engine

Overview:
Self-sequencing memory data-bus test engine: walks a single 1 (or single 0) across every data bit at one fixed test address, reading each pattern back and comparing it. Replaces the controller-plus-datapath split with one parametrised block that has its own state machine, a configurable read latency and a capture of the first failure. Sits between the test controller (start/result) and a single-port synchronous memory.

Parameters:
DATUM_WIDTH, 8, data bus width in bits (>=2)
ADDR_WIDTH, 8, memory address width in bits (>=1)
READ_LATENCY, 1, cycles from read-enable cycle to valid i_mem_rdata (>=1)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n_async  in  1  asynchronous active-low reset
i_start  in  1  start request, sampled only in IDLE
i_abort  in  1  synchronous abort, returns to IDLE from any state
i_mode  in  1  0 = walking ones, 1 = walking zeros; latched at start
i_test_addr  in  ADDR_WIDTH  address under test; latched at start
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_wr_en  out  1  write strobe
o_mem_rd_en  out  1  read strobe
o_mem_wdata  out  DATUM_WIDTH  write data
i_mem_rdata  in  DATUM_WIDTH  read data
o_busy  out  1  high in any state other than IDLE and DONE
o_done  out  1  one-cycle completion pulse
o_pass  out  1  result, valid from o_done until next accepted start
o_fail_pattern  out  DATUM_WIDTH  expected word of first mismatch, 0 on pass
o_fail_data  out  DATUM_WIDTH  read word of first mismatch, 0 on pass

Behaviour:
- Reset: state IDLE; all outputs 0; internal pattern, latched address/mode and latency counter 0.
- States: IDLE, WRITE, READ, WAIT, CHECK, DONE.
- IDLE: i_start=1 -> latch i_test_addr and i_mode, walk register = 1 (bit 0 set), clear o_pass/o_fail_*; go WRITE. i_start in any other state ignored.
- Driven word = walk register (mode 0) or its bitwise inverse (mode 1).
- WRITE (1 cycle): o_mem_wr_en=1, o_mem_wdata = driven word, o_mem_addr = latched address -> READ.
- READ (1 cycle): o_mem_rd_en=1 -> WAIT if READ_LATENCY>1 (counter loaded READ_LATENCY-2, WAIT lasts READ_LATENCY-1 cycles), else CHECK.
- CHECK (1 cycle): sample i_mem_rdata. Mismatch vs driven word -> o_fail_pattern = driven word, o_fail_data = rdata, o_pass=0, go DONE. Match and walk register MSB set -> o_pass=1, go DONE. Match otherwise -> walk register shifted left by 1, go WRITE.
- DONE (1 cycle): o_done=1 -> IDLE. o_pass/o_fail_* held until next accepted start.
- Strobes and o_mem_wdata are 0 outside WRITE/READ; o_mem_addr holds latched address while busy, 0 in IDLE after reset.
- Timing: each pattern takes 2+READ_LATENCY cycles; pass run: o_done high DATUM_WIDTH*(2+READ_LATENCY) cycles after the start-sampling edge. Fail at pattern k (0-based): o_done k*(2+READ_LATENCY)+(2+READ_LATENCY) cycles after start edge.
- i_abort=1: next state IDLE, no o_done, results cleared to 0, strobes deasserted same edge; abort has priority over start and over CHECK outcome.
- Asynchronous reset mid-test: immediate return to reset values, no o_done.
- Walk register never zero while busy; only DATUM_WIDTH patterns are tested (no all-zero/all-one pattern).

Test Plan:
- Mode 0, W=8, L=1, ideal memory, start addr 0x3C -> writes 0x01,0x02..0x80 to 0x3C; o_done at cycle 24 after start, o_pass=1, fail outputs 0.
- Mode 1, same setup -> writes 0xFE,0xFD..0x7F; o_pass=1 at cycle 24.
- Mode 0, memory with data bit 4 stuck at 0 -> o_done at cycle 15, o_pass=0, o_fail_pattern=0x10, o_fail_data=0x00.
- READ_LATENCY=3, W=16, mode 0, ideal memory -> 16 patterns, rd_en-to-check gap 3 cycles, o_done at cycle 80, o_pass=1.
- i_abort asserted during 4th WRITE -> IDLE next cycle, no o_done, o_busy=0; subsequent start completes a full pass normally.
- i_start held high through a run and i_rst_n_async pulsed low mid-READ -> extra starts ignored while busy; reset clears all outputs asynchronously, state IDLE.

Source files
------------

// File: rtl/memtest_databus_if.sv
// Control and memory-bus signals of the data-bus test engine.
// The master side is the engine; the slave side is the controller plus memory it serves.
interface memtest_databus_if #(
    parameter int DATUM_WIDTH = 8,
    parameter int ADDR_WIDTH  = 8
);
    logic                   i_start;
    logic                   i_abort;
    logic                   i_mode;
    logic [ADDR_WIDTH-1:0]  i_test_addr;
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic                   o_mem_wr_en;
    logic                   o_mem_rd_en;
    logic [DATUM_WIDTH-1:0] o_mem_wdata;
    logic [DATUM_WIDTH-1:0] i_mem_rdata;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_pass;
    logic [DATUM_WIDTH-1:0] o_fail_pattern;
    logic [DATUM_WIDTH-1:0] o_fail_data;

    modport master (
        input  i_start, i_abort, i_mode, i_test_addr, i_mem_rdata,
        output o_mem_addr, o_mem_wr_en, o_mem_rd_en, o_mem_wdata,
               o_busy, o_done, o_pass, o_fail_pattern, o_fail_data
    );

    modport slave (
        output i_start, i_abort, i_mode, i_test_addr, i_mem_rdata,
        input  o_mem_addr, o_mem_wr_en, o_mem_rd_en, o_mem_wdata,
               o_busy, o_done, o_pass, o_fail_pattern, o_fail_data
    );
endinterface

// File: rtl/memtest_databus_engine.sv
// Walking-one / walking-zero data-bus test at a single address, with its own
// sequencer, configurable read latency and capture of the first mismatch.
module memtest_databus_engine #(
    parameter int DATUM_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n_async,
    memtest_databus_if.master bus
);
    localparam int CNT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t                 state;
    logic [DATUM_WIDTH-1:0] walk;
    logic                   mode_q;
    logic [CNT_W-1:0]       lat_cnt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   wr_en_q;
    logic                   rd_en_q;
    logic [DATUM_WIDTH-1:0] wdata_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [DATUM_WIDTH-1:0] fail_pattern_q;
    logic [DATUM_WIDTH-1:0] fail_data_q;

    logic [DATUM_WIDTH-1:0] walk_next;
    logic [DATUM_WIDTH-1:0] check_word;

    function automatic logic [DATUM_WIDTH-1:0] drive_word(input logic mode,
                                                          input logic [DATUM_WIDTH-1:0] w);
        return mode ? ~w : w;
    endfunction

    assign walk_next  = walk << 1;
    assign check_word = drive_word(mode_q, walk);

    always_ff @(posedge i_clk or negedge i_rst_n_async) begin
        if (!i_rst_n_async) begin
            state          <= S_IDLE;
            walk           <= '0;
            mode_q         <= 1'b0;
            lat_cnt        <= '0;
            addr_q         <= '0;
            wr_en_q        <= 1'b0;
            rd_en_q        <= 1'b0;
            wdata_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_pattern_q <= '0;
            fail_data_q    <= '0;
        end else begin
            done_q <= 1'b0;
            // Abort wins over start and over the outcome of a check.
            if (bus.i_abort) begin
                state          <= S_IDLE;
                wr_en_q        <= 1'b0;
                rd_en_q        <= 1'b0;
                wdata_q        <= '0;
                busy_q         <= 1'b0;
                pass_q         <= 1'b0;
                fail_pattern_q <= '0;
                fail_data_q    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            mode_q         <= bus.i_mode;
                            addr_q         <= bus.i_test_addr;
                            walk           <= DATUM_WIDTH'(1);
                            pass_q         <= 1'b0;
                            fail_pattern_q <= '0;
                            fail_data_q    <= '0;
                            wr_en_q        <= 1'b1;
                            wdata_q        <= drive_word(bus.i_mode, DATUM_WIDTH'(1));
                            busy_q         <= 1'b1;
                            state          <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        wr_en_q <= 1'b0;
                        wdata_q <= '0;
                        rd_en_q <= 1'b1;
                        state   <= S_READ;
                    end
                    S_READ: begin
                        rd_en_q <= 1'b0;
                        if (READ_LATENCY > 1) begin
                            lat_cnt <= LAT_LOAD;
                            state   <= S_WAIT;
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                    S_WAIT: begin
                        if (lat_cnt == '0) state <= S_CHECK;
                        else               lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                    S_CHECK: begin
                        if (bus.i_mem_rdata != check_word) begin
                            fail_pattern_q <= check_word;
                            fail_data_q    <= bus.i_mem_rdata;
                            pass_q         <= 1'b0;
                            busy_q         <= 1'b0;
                            done_q         <= 1'b1;
                            state          <= S_DONE;
                        end else if (walk[DATUM_WIDTH-1]) begin
                            pass_q <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            walk    <= walk_next;
                            wr_en_q <= 1'b1;
                            wdata_q <= drive_word(mode_q, walk_next);
                            state   <= S_WRITE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_mem_addr     = addr_q;
    assign bus.o_mem_wr_en    = wr_en_q;
    assign bus.o_mem_rd_en    = rd_en_q;
    assign bus.o_mem_wdata    = wdata_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_pass         = pass_q;
    assign bus.o_fail_pattern = fail_pattern_q;
    assign bus.o_fail_data    = fail_data_q;
endmodule

// File: tb/tb_memtest_databus_engine.sv
// Bench for memtest_databus_engine: an 8-bit/latency-1 instance and a 16-bit/latency-3
// instance, each against a behavioural memory with optional stuck-at data bits.
module tb_memtest_databus_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    memtest_databus_if #(.DATUM_WIDTH(8),  .ADDR_WIDTH(8)) ifa ();
    memtest_databus_if #(.DATUM_WIDTH(16), .ADDR_WIDTH(8)) ifb ();

    memtest_databus_engine #(.DATUM_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) dut_a (
        .i_clk(clk), .i_rst_n_async(rst_n), .bus(ifa));
    memtest_databus_engine #(.DATUM_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(3)) dut_b (
        .i_clk(clk), .i_rst_n_async(rst_n), .bus(ifb));

    // Memory A: one-cycle read latency, stuck-at masks applied on read.
    logic [7:0]  mem_a [256];
    logic [7:0]  s0_a = 8'h00, s1_a = 8'h00;
    logic [15:0] wlog_a [$];
    always @(posedge clk) begin
        if (ifa.o_mem_wr_en) begin
            mem_a[ifa.o_mem_addr] <= ifa.o_mem_wdata;
            wlog_a.push_back({ifa.o_mem_addr, ifa.o_mem_wdata});
        end
        if (ifa.o_mem_rd_en) ifa.i_mem_rdata <= (mem_a[ifa.o_mem_addr] & ~s0_a) | s1_a;
    end

    // Memory B: three-cycle read latency through a holding pipeline.
    logic [15:0] mem_b [256];
    logic [15:0] s0_b = 16'h0, s1_b = 16'h0;
    logic [15:0] pb0, pb1, pb2;
    logic [23:0] wlog_b [$];
    always @(posedge clk) begin
        if (ifb.o_mem_wr_en) begin
            mem_b[ifb.o_mem_addr] <= ifb.o_mem_wdata;
            wlog_b.push_back({ifb.o_mem_addr, ifb.o_mem_wdata});
        end
        if (ifb.o_mem_rd_en) pb0 <= (mem_b[ifb.o_mem_addr] & ~s0_b) | s1_b;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ifb.i_mem_rdata = pb2;

    function automatic logic [15:0] pat_of(input int w, input bit mode, input int k);
        logic [15:0] m;
        logic [15:0] p;
        m = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
        p = 16'h1 << k;
        return mode ? (~p & m) : p;
    endfunction

    // Reference: patterns in order, first read-back that differs ends the run.
    function automatic void model_run(input int w, input int lat, input bit mode,
                                      input logic [15:0] s0, input logic [15:0] s1,
                                      output int done_cyc, output bit pass,
                                      output logic [15:0] fpat, output logic [15:0] fdat,
                                      output int npat);
        logic [15:0] p, r;
        pass = 1'b1; fpat = 16'h0; fdat = 16'h0; npat = w; done_cyc = w * (2 + lat);
        for (int k = 0; k < w; k++) begin
            p = pat_of(w, mode, k);
            r = (p & ~s0) | s1;
            if (r != p) begin
                pass = 1'b0; fpat = p; fdat = r; npat = k + 1; done_cyc = (k + 1) * (2 + lat);
                break;
            end
        end
    endfunction

    task automatic run_a(input bit mode, input logic [7:0] addr, input bit hold,
                         output int dcyc, output bit pass, output logic [7:0] fp,
                         output logic [7:0] fd, output int nwr);
        wlog_a.delete();
        ifa.i_mode = mode; ifa.i_test_addr = addr; ifa.i_start = 1'b1;
        @(posedge clk); @(negedge clk);
        if (!hold) ifa.i_start = 1'b0;
        dcyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (ifa.o_done) begin dcyc = c; break; end
        end
        pass = ifa.o_pass; fp = ifa.o_fail_pattern; fd = ifa.o_fail_data; nwr = wlog_a.size();
    endtask

    task automatic test_reset();
        n_total++;
        if ({ifa.o_busy, ifa.o_done, ifa.o_pass, ifa.o_mem_wr_en, ifa.o_mem_rd_en} !== 5'b0) begin
            $display("FAIL reset_ctrl_a got %b want 00000",
                     {ifa.o_busy, ifa.o_done, ifa.o_pass, ifa.o_mem_wr_en, ifa.o_mem_rd_en});
        end else n_pass++;
        n_total++;
        if ({ifa.o_mem_addr, ifa.o_mem_wdata, ifa.o_fail_pattern, ifa.o_fail_data} !== 32'h0) begin
            $display("FAIL reset_data_a got %h want 0",
                     {ifa.o_mem_addr, ifa.o_mem_wdata, ifa.o_fail_pattern, ifa.o_fail_data});
        end else n_pass++;
        n_total++;
        if ({ifb.o_busy, ifb.o_done, ifb.o_pass, ifb.o_mem_wr_en, ifb.o_mem_rd_en, ifb.o_fail_pattern} !== 21'h0) begin
            $display("FAIL reset_b got %h want 0",
                     {ifb.o_busy, ifb.o_done, ifb.o_pass, ifb.o_mem_wr_en, ifb.o_mem_rd_en, ifb.o_fail_pattern});
        end else n_pass++;
    endtask

    task automatic test_walk_run(input bit mode, input logic [7:0] addr,
                                 input logic [7:0] s0, input logic [7:0] s1, input string name);
        int dcyc, nwr, edc, enp;
        bit pass, ep;
        logic [7:0] fp, fd;
        logic [15:0] efp, efd, expw;
        s0_a = s0; s1_a = s1;
        run_a(mode, addr, 1'b0, dcyc, pass, fp, fd, nwr);
        model_run(8, 1, mode, {8'h0, s0}, {8'h0, s1}, edc, ep, efp, efd, enp);
        n_total++;
        if (dcyc !== edc) $display("FAIL %s done_cycle got %0d want %0d", name, dcyc, edc);
        else n_pass++;
        n_total++;
        if (pass !== ep) $display("FAIL %s pass got %b want %b", name, pass, ep);
        else n_pass++;
        n_total++;
        if ({fp, fd} !== {efp[7:0], efd[7:0]})
            $display("FAIL %s fail_pattern/data got %h/%h want %h/%h", name, fp, fd, efp[7:0], efd[7:0]);
        else n_pass++;
        n_total++;
        if (nwr !== enp) $display("FAIL %s write_count got %0d want %0d", name, nwr, enp);
        else n_pass++;
        for (int i = 0; i < nwr && i < enp; i++) begin
            expw = {addr, 8'(pat_of(8, mode, i))};
            n_total++;
            if (wlog_a[i] !== expw) $display("FAIL %s write_%0d got %h want %h", name, i, wlog_a[i], expw);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({ifa.o_done, ifa.o_busy} !== 2'b00)
            $display("FAIL %s after_done done/busy got %b want 00", name, {ifa.o_done, ifa.o_busy});
        else n_pass++;
    endtask

    task automatic test_directed();
        test_walk_run(1'b0, 8'h3C, 8'h00, 8'h00, "walk_ones");
        test_walk_run(1'b1, 8'h3C, 8'h00, 8'h00, "walk_zeros");
        test_walk_run(1'b0, 8'h3C, 8'h10, 8'h00, "stuck0_bit4");
    endtask

    task automatic test_random();
        int ft, b;
        logic [7:0] s0, s1;
        for (int r = 0; r < 6; r++) begin
            ft = int'($urandom_range(0, 2));
            b  = int'($urandom_range(0, 7));
            s0 = (ft == 1) ? 8'(1 << b) : 8'h00;
            s1 = (ft == 2) ? 8'(1 << b) : 8'h00;
            test_walk_run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), s0, s1, "random_a");
        end
    endtask

    task automatic test_latency3();
        int dcyc, edc, enp, nwr, b;
        bit mode, ep;
        logic [7:0] addr;
        logic [15:0] efp, efd;
        logic [23:0] expw;
        for (int r = 0; r < 2; r++) begin
            mode = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            b    = int'($urandom_range(0, 15));
            s0_b = (r == 0) ? 16'h0 : 16'(1 << b);
            s1_b = 16'h0;
            addr = 8'($urandom_range(0, 255));
            wlog_b.delete();
            ifb.i_mode = mode; ifb.i_test_addr = addr; ifb.i_start = 1'b1;
            @(posedge clk); @(negedge clk);
            ifb.i_start = 1'b0;
            dcyc = -1;
            for (int c = 1; c <= 400; c++) begin
                @(posedge clk); @(negedge clk);
                if (ifb.o_done) begin dcyc = c; break; end
            end
            nwr = wlog_b.size();
            model_run(16, 3, mode, s0_b, s1_b, edc, ep, efp, efd, enp);
            n_total++;
            if (dcyc !== edc) $display("FAIL lat3_done_cycle got %0d want %0d", dcyc, edc);
            else n_pass++;
            n_total++;
            if ({ifb.o_pass, ifb.o_fail_pattern, ifb.o_fail_data} !== {ep, efp, efd})
                $display("FAIL lat3_result got %b/%h/%h want %b/%h/%h", ifb.o_pass,
                         ifb.o_fail_pattern, ifb.o_fail_data, ep, efp, efd);
            else n_pass++;
            n_total++;
            if (nwr !== enp) $display("FAIL lat3_write_count got %0d want %0d", nwr, enp);
            else n_pass++;
            for (int i = 0; i < nwr && i < enp; i++) begin
                expw = {addr, pat_of(16, mode, i)};
                n_total++;
                if (wlog_b[i] !== expw) $display("FAIL lat3_write_%0d got %h want %h", i, wlog_b[i], expw);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int nw;
        bit hit, done_seen;
        s0_a = 8'h00; s1_a = 8'h00;
        wlog_a.delete();
        nw = 0; hit = 1'b0; done_seen = 1'b0;
        ifa.i_mode = 1'($urandom_range(0, 1)); ifa.i_test_addr = 8'h5A; ifa.i_start = 1'b1;
        @(posedge clk); @(negedge clk);
        ifa.i_start = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            if (ifa.o_mem_wr_en) nw++;
            if (nw == 4) hit = 1'b1;
            else begin @(posedge clk); @(negedge clk); end
        end
        n_total++;
        if (hit !== 1'b1) $display("FAIL abort_reach_4th_write got %0d writes want 4", nw);
        else n_pass++;
        ifa.i_abort = 1'b1;
        @(posedge clk); @(negedge clk);
        ifa.i_abort = 1'b0;
        n_total++;
        if ({ifa.o_busy, ifa.o_done, ifa.o_pass, ifa.o_mem_wr_en, ifa.o_mem_rd_en, ifa.o_mem_wdata} !== 13'h0)
            $display("FAIL abort_outputs got %h want 0",
                     {ifa.o_busy, ifa.o_done, ifa.o_pass, ifa.o_mem_wr_en, ifa.o_mem_rd_en, ifa.o_mem_wdata});
        else n_pass++;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (ifa.o_done || ifa.o_busy || ifa.o_mem_wr_en) done_seen = 1'b1;
        end
        n_total++;
        if (done_seen !== 1'b0) $display("FAIL abort_stays_idle got activity=1 want 0");
        else n_pass++;
        n_total++;
        if (wlog_a.size() !== 4) $display("FAIL abort_write_count got %0d want 4", wlog_a.size());
        else n_pass++;
        test_walk_run(1'b0, 8'h21, 8'h00, 8'h00, "after_abort");
    endtask

    task automatic test_hold_reset();
        int dcyc, nwr;
        bit pass, found;
        logic [7:0] fp, fd;
        s0_a = 8'h00; s1_a = 8'h00;
        run_a(1'b0, 8'h3C, 1'b1, dcyc, pass, fp, fd, nwr);
        n_total++;
        if ({dcyc, nwr, pass} !== {32'd24, 32'd8, 1'b1})
            $display("FAIL hold_start_run got cyc=%0d writes=%0d pass=%b want 24/8/1", dcyc, nwr, pass);
        else n_pass++;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); @(negedge clk);
            if (ifa.o_mem_rd_en) found = 1'b1;
        end
        n_total++;
        if (found !== 1'b1) $display("FAIL hold_restart_read got rd_en=0 want 1");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({ifa.o_busy, ifa.o_done, ifa.o_pass, ifa.o_mem_wr_en, ifa.o_mem_rd_en} !== 5'b0)
            $display("FAIL async_reset_ctrl got %b want 00000",
                     {ifa.o_busy, ifa.o_done, ifa.o_pass, ifa.o_mem_wr_en, ifa.o_mem_rd_en});
        else n_pass++;
        n_total++;
        if ({ifa.o_mem_addr, ifa.o_mem_wdata, ifa.o_fail_pattern, ifa.o_fail_data} !== 32'h0)
            $display("FAIL async_reset_data got %h want 0",
                     {ifa.o_mem_addr, ifa.o_mem_wdata, ifa.o_fail_pattern, ifa.o_fail_data});
        else n_pass++;
        ifa.i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (ifa.o_done || ifa.o_busy) found = 1'b1;
        end
        n_total++;
        if (found !== 1'b0) $display("FAIL reset_no_done got activity=1 want 0");
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.i_start = 1'b0; ifa.i_abort = 1'b0; ifa.i_mode = 1'b0; ifa.i_test_addr = 8'h00;
        ifb.i_start = 1'b0; ifb.i_abort = 1'b0; ifb.i_mode = 1'b0; ifb.i_test_addr = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_random();
        test_latency3();
        test_abort();
        test_hold_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
